// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel/line position, line length, frame height,
// lock status and display enable from an active-low HS/VS pair that shares
// the pixel clock with its source. No pixel data passes through this block.
module vga_sync_decoder #(
   parameter int H_START     = 0,
   parameter int H_ACTIVE    = 640,
   parameter int V_START     = 0,
   parameter int V_ACTIVE    = 480,
   parameter int LOCK_FRAMES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       vga_h_sync,
   input  logic       vga_v_sync,
   output logic [9:0] rx_x,
   output logic [9:0] rx_y,
   output logic [9:0] line_len,
   output logic [9:0] frame_lines,
   output logic       locked,
   output logic       rx_de,
   output logic       sync_lost
);

   // Lock state machine encoding
   localparam logic [1:0] S_ARM     = 2'd0;
   localparam logic [1:0] S_MEASURE = 2'd1;
   localparam logic [1:0] S_TRACK   = 2'd2;
   localparam logic [1:0] S_LOCKED  = 2'd3;

   localparam logic [1:0]  LOCK_N = 2'(LOCK_FRAMES);
   localparam logic [9:0]  CNT_MAX = 10'd1023;
   localparam logic [9:0]  CNT_PRE = 10'd1022;

   // Active window bounds, 11 bits wide so H_START+H_ACTIVE == 1024 is exact
   localparam logic [10:0] H_LO  = 11'(H_START);
   localparam logic [10:0] H_ACT = 11'(H_ACTIVE);
   localparam logic [10:0] V_LO  = 11'(V_START);
   localparam logic [10:0] V_ACT = 11'(V_ACTIVE);

   logic       r_hs_d;
   logic       r_vs_line;
   logic [9:0] r_rx_x;
   logic [9:0] r_rx_y;
   logic [9:0] r_line_len;
   logic [9:0] r_frame_lines;
   logic       r_hs_seen;
   logic       r_frame_seen;
   logic       r_len_chg;
   logic [1:0] r_state;
   logic [1:0] r_match;
   logic       r_sync_lost;

   logic        w_hs_fall;
   logic        w_frame_start;
   logic [9:0]  w_new_len;
   logic [9:0]  w_new_frame;
   logic        w_len_chg_now;
   logic        w_frame_chg;
   logic        w_good;
   logic [1:0]  w_match_inc;
   logic        w_timeout;
   logic [10:0] w_h_ofs;
   logic [10:0] w_v_ofs;

   // HS edge is taken against the live input so rx_x restarts on the same edge
   assign w_hs_fall     = r_hs_d & ~vga_h_sync;
   // VS is only qualified at HS falls: a frame starts on the first low sample
   assign w_frame_start = w_hs_fall & ~vga_v_sync & r_vs_line;

   assign w_new_len     = r_rx_x + 10'd1;
   assign w_new_frame   = r_rx_y + 10'd1;
   // A line-length change landing on a frame start must still spoil that frame
   assign w_len_chg_now = w_hs_fall & r_hs_seen & (w_new_len != r_line_len);
   assign w_frame_chg   = (w_new_frame != r_frame_lines);
   assign w_good        = ~r_len_chg & ~w_len_chg_now & ~w_frame_chg;
   assign w_match_inc   = (r_match == 2'd3) ? 2'd3 : r_match + 2'd1;

   // Loss of sync: a counter is one step from saturating and no HS edge rescues it
   assign w_timeout = ((r_rx_x == CNT_PRE) & ~w_hs_fall) |
                      ((r_rx_y == CNT_PRE) & w_hs_fall & ~w_frame_start);

   // Offset compare: values below the window start wrap to >= 1024 and fail
   assign w_h_ofs = {1'b0, r_rx_x} - H_LO;
   assign w_v_ofs = {1'b0, r_rx_y} - V_LO;

   assign rx_x        = r_rx_x;
   assign rx_y        = r_rx_y;
   assign line_len    = r_line_len;
   assign frame_lines = r_frame_lines;
   assign locked      = (r_state == S_LOCKED);
   assign sync_lost   = r_sync_lost;
   assign rx_de       = locked & (w_h_ofs < H_ACT) & (w_v_ofs < V_ACT);

   // Previous-cycle HS sample for falling-edge detection
   always_ff @(posedge clk) begin
      if (reset) r_hs_d <= 1'b1;
      else       r_hs_d <= vga_h_sync;
   end

   // Pixel counter and line-length measurement
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rx_x     <= '0;
         r_line_len <= '0;
      end else if (w_hs_fall) begin
         r_rx_x <= '0;
         if (r_hs_seen) r_line_len <= w_new_len;
      end else if (r_rx_x != CNT_MAX) begin
         r_rx_x <= r_rx_x + 10'd1;
      end
   end

   // Line counter, VS qualification and frame-height measurement
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rx_y        <= '0;
         r_frame_lines <= '0;
         r_vs_line     <= 1'b1;
      end else if (w_hs_fall) begin
         r_vs_line <= vga_v_sync;
         if (w_frame_start) begin
            r_rx_y <= '0;
            if (r_frame_seen) r_frame_lines <= w_new_frame;
         end else if (r_rx_y != CNT_MAX) begin
            r_rx_y <= r_rx_y + 10'd1;
         end
      end
   end

   // Lock tracking, advanced on frame starts; timeout drops back to ARM
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_ARM;
         r_match      <= '0;
         r_hs_seen    <= 1'b0;
         r_frame_seen <= 1'b0;
         r_len_chg    <= 1'b0;
         r_sync_lost  <= 1'b0;
      end else begin
         r_sync_lost <= w_timeout;
         if (w_timeout) begin
            r_state      <= S_ARM;
            r_match      <= '0;
            r_hs_seen    <= 1'b0;
            r_frame_seen <= 1'b0;
            r_len_chg    <= 1'b0;
         end else begin
            if (w_hs_fall) begin
               r_hs_seen <= 1'b1;
               if (w_len_chg_now) r_len_chg <= 1'b1;
            end
            if (w_frame_start) begin
               r_len_chg <= 1'b0;
               case (r_state)
                  S_ARM: begin
                     r_state      <= S_MEASURE;
                     r_frame_seen <= 1'b1;
                  end
                  S_MEASURE: begin
                     r_state <= S_TRACK;
                     r_match <= '0;
                  end
                  default: begin
                     if (w_good) begin
                        r_match <= w_match_inc;
                        if (w_match_inc >= LOCK_N) r_state <= S_LOCKED;
                     end else begin
                        r_match <= '0;
                        r_state <= S_TRACK;
                     end
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Receive-side counterpart of the VGA sync generator. It watches the active-low horizontal/vertical sync pair and recovers pixel/line counters, the measured line length, the measured frame height, a lock flag and a display-enable. It sits on a loopback or capture path, typically fed from the generator's `vga_h_sync`/`vga_v_sync`, to check video timing and to drive overlay or capture logic. There is no pixel-data path.

## Interface
Parameters:
- `H_START`, default 0: first `rx_x` value of the active region.
- `H_ACTIVE`, default 640: active pixels per line.
- `V_START`, default 0: first `rx_y` value of the active region.
- `V_ACTIVE`, default 480: active lines per frame.
- `LOCK_FRAMES`, default 2: consecutive matching frames required for lock (range 1..3).

Ports:
- One clock; reset is synchronous and active-high.
- `clk`, in, 1: pixel clock, rising edge. Same clock as the sync source.
- `reset`, in, 1: synchronous, active-high.
- `vga_h_sync`, in, 1: horizontal sync, active-low, synchronous to `clk`.
- `vga_v_sync`, in, 1: vertical sync, active-low, synchronous to `clk`.
- `rx_x`, out, 10: clocks since the last HS fall.
- `rx_y`, out, 10: lines since the last frame start.
- `line_len`, out, 10: last measured HS-fall-to-HS-fall period, in clocks.
- `frame_lines`, out, 10: last measured frame height, in lines.
- `locked`, out, 1: timing stable.
- `rx_de`, out, 1: display enable.
- `sync_lost`, out, 1: one-cycle pulse on timeout.

## Operation
Input sampling and edge detect:
- `hs_d` and `vs_d` hold the previous-cycle input samples; both reset to 1.
- `hs_fall = hs_d & ~vga_h_sync`, evaluated on the live input.

Horizontal counter:
- On `hs_fall`: `rx_x <= 0`; `hs_seen <= 1`.
  - If `hs_seen` was already set: `line_len <= rx_x + 1`.
  - If the new value differs from the old `line_len`, set `len_chg`.
- Otherwise `rx_x <= rx_x + 1`, saturating at 1023.

Vertical counter:
- `vs_line` holds the `vga_v_sync` level sampled at the previous `hs_fall`; it resets to 1.
- A frame start is an `hs_fall` with `vga_v_sync==0` and `vs_line==1`.
- On frame start: `rx_y <= 0`.
  - If `frame_seen`: `frame_lines <= rx_y + 1`.
  - Compare the new `frame_lines` against the old value.
- On any other `hs_fall`: `rx_y <= rx_y + 1`, saturating at 1023.

Lock state machine (ARM, MEASURE, TRACK, LOCKED), advancing on frame starts only:
- ARM to MEASURE: first frame start; sets `frame_seen`.
- MEASURE to TRACK: next frame start; captures `frame_lines`; `match <= 0`.
- In TRACK or LOCKED, each frame start is "good" if `len_chg==0` and the new `frame_lines` equals the old value.
  - Good frame: `match <= min(match+1, 3)`.
  - Bad frame: `match <= 0`, state goes to TRACK.
- TRACK to LOCKED when `match` reaches `LOCK_FRAMES`.
- `len_chg` clears at every frame start.

Timeout (loss of sync):
- Triggered when `rx_x` is about to saturate, i.e. `rx_x==1022` with no `hs_fall`, or `rx_y` would saturate.
- Effect: `sync_lost` pulses for 1 cycle; state goes to ARM; `locked`, `match`, `hs_seen`, `frame_seen` and `len_chg` clear.
- `line_len` and `frame_lines` hold their last values.
- Counters stay saturated until the next `hs_fall`.

Display enable:
- `rx_de = locked & (H_START <= rx_x < H_START+H_ACTIVE) & (V_START <= rx_y < V_START+V_ACTIVE)`.
- Combinational from registered state; no added latency relative to `rx_x`/`rx_y`.
- Comparisons are 11-bit unsigned, so parameter sums up to 1024 do not wrap.

## Timing
- Reset values: `rx_x`, `rx_y`, `line_len`, `frame_lines` = 0; `locked`, `rx_de`, `sync_lost` = 0; state ARM.
- Reset asserted mid-frame takes effect on the next edge and wins over every other event.
- `rx_x` reads 0 in the cycle after the clock edge at which `vga_h_sync` is first sampled low.
- `line_len`, `frame_lines` and `locked` update one edge after the triggering `hs_fall`.
- `hs_fall` coinciding with the cycle that would saturate: the edge wins and no timeout occurs.
- Simultaneous frame start and `line_len` change: both are registered, and the frame counts as bad.
- `vga_v_sync` changing when there is no `hs_fall` is ignored; VS is only qualified at HS falls.

## Test plan
- Drive from the generator (801-clock lines, 16-clock HS, 526-line frames):
  - `line_len==801` and `frame_lines==526`.
  - `locked` rises one edge after the 4th frame start from reset (`LOCK_FRAMES=2`).
  - `rx_de` high for exactly 640 consecutive clocks on each of 480 lines.
- While locked, stretch one line to 802 clocks:
  - `line_len==802`; `locked` drops at the next frame start.
  - Re-locks after 2 further good frames.
- While locked, hold `vga_h_sync` high:
  - `sync_lost` pulses once when `rx_x` goes 1022→1023, 1023 clocks after the last HS fall.
  - `locked==0`; `rx_x` stays at 1023; `line_len` holds 801.
- While locked, remove one line per frame (525 lines): `frame_lines==525` and `locked` deasserts.
- Hold `vga_v_sync` low across 3 lines: only one frame start is produced, and `rx_y` keeps counting 1, 2.
- Assert `reset` mid-frame for 1 cycle: all outputs read 0 on the next cycle, and lock is reacquired per the first scenario.
